// File: rtl/m_axi_wr.sv
// m_axi_wr -- single-burst AXI4 write master.
//
// Accepts one write command (start address + awlen), issues it on AW, then
// passes write beats straight from the din stream onto W, waits for the B
// response and reports it with a one-cycle done pulse.
//
// Optional feature: define M_AXI_WR_BOUNDARY_EN to reject bursts that would
// cross a 4 KB boundary. A rejected burst skips AW/W/B, consumes no din beats
// and finishes with done_resp = 2'b10 (SLVERR).
//
// Ports
//   m_axi_aclk, m_axi_areset : clock, synchronous active-high reset
//   cmd_*                    : command in (valid/ready, addr, len)
//   din_*                    : write beats in (valid/ready, data, strb)
//   done_valid, done_resp    : completion pulse and its response
//   m_axi_aw* / m_axi_w* / m_axi_b* : AXI4 write channels
//   dbg_state                : current FSM state (IDLE=0 ADDR=1 DATA=2 RESP=3 DONE=4)
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a valid, once raised, holds itself and its
// payload stable until that edge, and never waits on ready to rise.
module m_axi_wr #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [DATA_WIDTH-1:0]     din_data,
  input  logic [DATA_WIDTH/8-1:0]   din_strb,
  output logic                      done_valid,
  output logic [1:0]                done_resp,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_awuser,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [2:0]                dbg_state
);

  localparam int         BYTES   = DATA_WIDTH / 8;
  localparam logic [2:0] AW_SIZE = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] beat_cnt;   // beats still to send after the current one
  logic       in_data;
  logic       cross_4k;

  // Constant AW attributes: full-width INCR bursts, no special attributes.
  assign m_axi_awid    = '0;
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awuser  = 1'b0;

  // W is a zero-latency pass-through of din, opened only in DATA so no
  // write beat can precede the completed address handshake.
  assign in_data      = (state == S_DATA);
  assign m_axi_wvalid = in_data & din_valid;
  assign din_ready    = in_data & m_axi_wready;
  assign m_axi_wdata  = din_data;
  assign m_axi_wstrb  = din_strb;
  assign m_axi_wlast  = in_data & (beat_cnt == 8'd0);

  assign dbg_state = state;

`ifdef M_AXI_WR_BOUNDARY_EN
  // End offset of the burst within its 4 KB page; up to 256 beats of
  // 128 bytes plus a 12-bit start offset fits in 18 bits.
  logic [17:0] burst_end;
  assign burst_end = 18'(cmd_addr[11:0]) + 18'((32'(cmd_len) + 32'd1) * BYTES);
  assign cross_4k  = (burst_end > 18'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  // The response ID is not used: only one burst is ever outstanding.
  logic unused_ok;
  assign unused_ok = ^m_axi_bid;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      done_valid    <= 1'b0;
      done_resp     <= 2'b00;
      beat_cnt      <= 8'd0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready    <= 1'b0;
            m_axi_awaddr <= cmd_addr;
            m_axi_awlen  <= cmd_len;
            beat_cnt     <= cmd_len;
            if (cross_4k) begin
              // Rejected burst: report SLVERR without touching the bus.
              state      <= S_DONE;
              done_valid <= 1'b1;
              done_resp  <= 2'b10;
            end else begin
              state         <= S_ADDR;
              m_axi_awvalid <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_axi_wvalid && m_axi_wready) begin
            if (beat_cnt == 8'd0) begin
              state        <= S_RESP;
              m_axi_bready <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            done_resp    <= m_axi_bresp;
            done_valid   <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          done_valid <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state         <= S_IDLE;
          cmd_ready     <= 1'b1;
          m_axi_awvalid <= 1'b0;
          m_axi_bready  <= 1'b0;
          done_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_axi_wr.sv
// tb_m_axi_wr -- directed bench for m_axi_wr (default parameters).
// Clock/reset block, driver tasks for the command/din side and the AXI slave
// side, a W-channel scoreboard fed from an expected queue, and a final report.
`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

module tb_m_axi_wr;
  localparam int ID_W = 1;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SW   = DW / 8;

  logic            m_axi_aclk;
  logic            m_axi_areset;
  logic            cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic            din_valid, din_ready;
  logic [DW-1:0]   din_data;
  logic [SW-1:0]   din_strb;
  logic            done_valid;
  logic [1:0]      done_resp;
  logic [ID_W-1:0] m_axi_awid;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awlock;
  logic [3:0]      m_axi_awcache;
  logic [2:0]      m_axi_awprot;
  logic [3:0]      m_axi_awqos;
  logic            m_axi_awuser;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [ID_W-1:0] m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic [2:0]      dbg_state;

  m_axi_wr #(.ID_WIDTH(ID_W), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_strb(din_strb),
    .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial m_axi_aclk = 1'b0;
  always #5 m_axi_aclk = ~m_axi_aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+SW:0] exp_q[$];      // {wlast, wstrb, wdata} per expected beat
  logic [DW+SW:0] mon_exp;
  int   beats_seen = 0;
  int   wlast_cnt  = 0;
  int   awv_cycles = 0;
  int   early_w    = 0;
  logic aw_seen    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      aw_seen = 1'b0;
    end else begin
      if (m_axi_awvalid) awv_cycles++;
      if (m_axi_wvalid && !aw_seen) early_w++;
      if (m_axi_awvalid && m_axi_awready) aw_seen = 1'b1;
      if (m_axi_wvalid && m_axi_wready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          `CHK("w_unexpected_beat", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          n_tests++;
          if (m_axi_wdata !== mon_exp[DW-1:0]) begin
            n_fail++;
            $error("FAIL wdata: observed 0x%0h expected 0x%0h", m_axi_wdata, mon_exp[DW-1:0]);
          end
          n_tests++;
          if (m_axi_wstrb !== mon_exp[DW+SW-1:DW]) begin
            n_fail++;
            $error("FAIL wstrb: observed 0x%0h expected 0x%0h", m_axi_wstrb, mon_exp[DW+SW-1:DW]);
          end
          n_tests++;
          if (m_axi_wlast !== mon_exp[DW+SW]) begin
            n_fail++;
            $error("FAIL wlast: observed %0b expected %0b", m_axi_wlast, mon_exp[DW+SW]);
          end
        end
        if (m_axi_wlast) begin
          wlast_cnt++;
          aw_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge m_axi_aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] addr, input logic [7:0] len);
    int i = 0;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    while (!cmd_ready && i < 20) begin tick(); i++; end
    `CHK("cmd_ready_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic aw_slave(input int dly, input logic [AW-1:0] a, input logic [7:0] l);
    int i = 0;
    while (!m_axi_awvalid && i < 50) begin tick(); i++; end
    `CHK("awvalid_seen", m_axi_awvalid, 1);
    `CHK("awaddr", m_axi_awaddr, a);
    `CHK("awlen", m_axi_awlen, l);
    repeat (dly) begin
      tick();
      `CHK("aw_hold_valid", m_axi_awvalid, 1);
      `CHK("aw_hold_addr", m_axi_awaddr, a);
      `CHK("aw_hold_len", m_axi_awlen, l);
    end
    m_axi_awready = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    `CHK("awvalid_dropped", m_axi_awvalid, 0);
  endtask

  task automatic w_master(input int len, input int gap, input logic [DW-1:0] base);
    int i;
    for (int b = 0; b <= len; b++) begin
      din_valid = 1'b0;
      repeat (gap) tick();
      din_valid = 1'b1;
      din_data  = base + 32'(b);
      din_strb  = 4'(b + 1);
      exp_q.push_back({(b == len), din_strb, din_data});
      i = 0;
      while (!din_ready && i < 100) begin tick(); i++; end
      `CHK("din_ready_timeout", din_ready, 1);
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic b_slave(input int wl0, input int dly, input logic [1:0] resp);
    int i = 0;
    while (wlast_cnt == wl0 && i < 300) begin tick(); i++; end
    `CHK("wlast_seen", (wlast_cnt != wl0), 1);
    repeat (dly) tick();
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    i = 0;
    while (!m_axi_bready && i < 20) begin tick(); i++; end
    `CHK("bready_timeout", m_axi_bready, 1);
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
  endtask

  task automatic wait_done(input logic [1:0] resp);
    int i = 0;
    while (!done_valid && i < 100) begin tick(); i++; end
    `CHK("done_seen", done_valid, 1);
    `CHK("done_resp", done_resp, resp);
    tick();
    `CHK("done_one_cycle", done_valid, 0);
    `CHK("cmd_ready_after_done", cmd_ready, 1);
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len, input int aw_dly,
                           input int gap, input int b_dly, input logic [1:0] resp);
    int wl0 = wlast_cnt;
    int bs0 = beats_seen;
    int av0 = awv_cycles;
    int ew0 = early_w;
    send_cmd(addr, len);
    fork
      aw_slave(aw_dly, addr, len);
      w_master(int'(len), gap, addr ^ 32'h5A5A_0000);
      b_slave(wl0, b_dly, resp);
    join
    wait_done(resp);
    `CHK("beat_count", beats_seen - bs0, int'(len) + 1);
    `CHK("awvalid_cycles", awv_cycles - av0, aw_dly + 1);
    `CHK("no_w_before_aw", early_w - ew0, 0);
    `CHK("exp_q_drained", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
    din_valid = 1'b0; din_data = '0; din_strb = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b1;
    m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    m_axi_areset = 1'b1;
    #1;
    tick(); tick();
    m_axi_areset = 1'b0;

    // Reset state and constant AW attributes.
    `CHK("rst_cmd_ready", cmd_ready, 1);
    `CHK("rst_awvalid", m_axi_awvalid, 0);
    `CHK("rst_wvalid", m_axi_wvalid, 0);
    `CHK("rst_bready", m_axi_bready, 0);
    `CHK("rst_done_valid", done_valid, 0);
    `CHK("rst_din_ready", din_ready, 0);
    `CHK("rst_done_resp", done_resp, 0);
    `CHK("rst_awaddr", m_axi_awaddr, 0);
    `CHK("rst_awlen", m_axi_awlen, 0);
    `CHK("rst_state", dbg_state, 0);
    `CHK("awsize", m_axi_awsize, 3'd2);
    `CHK("awburst", m_axi_awburst, 2'b01);
    `CHK("aw_zero_attrs", {m_axi_awid, m_axi_awlock, m_axi_awcache, m_axi_awprot,
                           m_axi_awqos, m_axi_awuser}, 0);

    // Four-beat burst, slave always ready.
    run_burst(32'h4000_0100, 8'd3, 0, 0, 0, 2'b00);
    // Single beat, awready held off 5 cycles, gaps on din.
    run_burst(32'h4000_0200, 8'd0, 5, 2, 0, 2'b00);
    // SLVERR response after a 3-cycle bvalid delay.
    run_burst(32'h4000_0300, 8'd1, 0, 0, 3, 2'b10);
    // Mixed stalls, OKAY-variant response passes through.
    run_burst(32'h4000_0380, 8'd2, 1, 1, 1, 2'b01);

    // Reset in the middle of an 8-beat burst, after two beats.
    send_cmd(32'h4000_0400, 8'd7);
    m_axi_awready = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      din_valid = 1'b1;
      din_data  = 32'hC0DE_0000 + 32'(b);
      din_strb  = 4'hF;
      exp_q.push_back({1'b0, din_strb, din_data});
      `CHK("mid_din_ready", din_ready, 1);
      tick();
    end
    din_valid = 1'b0;
    m_axi_areset = 1'b1;
    tick();
    m_axi_areset = 1'b0;
    `CHK("mid_rst_cmd_ready", cmd_ready, 1);
    `CHK("mid_rst_awvalid", m_axi_awvalid, 0);
    `CHK("mid_rst_bready", m_axi_bready, 0);
    `CHK("mid_rst_done_valid", done_valid, 0);
    `CHK("mid_rst_awaddr", m_axi_awaddr, 0);
    `CHK("mid_rst_state", dbg_state, 0);
    `CHK("mid_rst_exp_q", exp_q.size(), 0);
    din_valid = 1'b1;
    #1;
    `CHK("mid_rst_wvalid_gated", m_axi_wvalid, 0);
    `CHK("mid_rst_din_ready", din_ready, 0);
    din_valid = 1'b0;
    run_burst(32'h4000_0500, 8'd1, 0, 0, 0, 2'b00);

`ifdef M_AXI_WR_BOUNDARY_EN
    // 0xFF8 + 16 bytes crosses the 4 KB page: rejected without bus traffic.
    begin
      int bs0 = beats_seen;
      int av0 = awv_cycles;
      din_valid = 1'b1;
      din_data  = 32'hDEAD_BEEF;
      din_strb  = 4'hF;
      send_cmd(32'h4000_0FF8, 8'd3);
      `CHK("bnd_no_awvalid", m_axi_awvalid, 0);
      `CHK("bnd_din_ready", din_ready, 0);
      `CHK("bnd_wvalid", m_axi_wvalid, 0);
      wait_done(2'b10);
      din_valid = 1'b0;
      `CHK("bnd_no_beats", beats_seen - bs0, 0);
      `CHK("bnd_no_aw_cycles", awv_cycles - av0, 0);
    end
    // 0xFF0 + 16 bytes ends exactly on the page: issued.
    run_burst(32'h4000_0FF0, 8'd3, 0, 0, 0, 2'b00);
`else
    // Without the check, a page-crossing burst is issued as-is.
    run_burst(32'h4000_0FF8, 8'd3, 0, 0, 0, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
